// File: rtl/emin_sweep_ctrl_if.sv
// rtl/emin_sweep_ctrl_if.sv - sweep controller bundle: sequencer start/done, emin launch/stream, result buffer write
interface emin_sweep_ctrl_if #(
    parameter int BIT_WIDTH = 32,
    parameter int I         = 160
);
    localparam int IW = $clog2(I);

    logic                 start_in;
    logic [IW-1:0]        last_i_in;
    logic [IW-1:0]        emin_i_out;
    logic                 emin_valid_out;
    logic [IW-1:0]        emin_j_in;
    logic [BIT_WIDTH-1:0] emin_data_in;
    logic                 emin_valid_in;
    logic                 res_we_out;
    logic [IW-1:0]        res_addr_out;
    logic [BIT_WIDTH-1:0] res_val_out;
    logic [IW-1:0]        res_arg_out;
    logic                 busy_out;
    logic                 done_out;
    logic                 error_out;

    modport master (
        output start_in, last_i_in, emin_j_in, emin_data_in, emin_valid_in,
        input  emin_i_out, emin_valid_out, res_we_out, res_addr_out, res_val_out,
               res_arg_out, busy_out, done_out, error_out
    );

    modport slave (
        input  start_in, last_i_in, emin_j_in, emin_data_in, emin_valid_in,
        output emin_i_out, emin_valid_out, res_we_out, res_addr_out, res_val_out,
               res_arg_out, busy_out, done_out, error_out
    );
endinterface

// File: rtl/emin_sweep_ctrl.sv
// rtl/emin_sweep_ctrl.sv - sweeps emin over i = 0..last_i, reducing each Emin(j,i) stream to min/argmin
module emin_sweep_ctrl #(
    parameter int BIT_WIDTH = 32,
    parameter int I         = 160,
    parameter int TIMEOUT   = 64
) (
    input  logic              clk_in,
    input  logic              rst_n_in,
    emin_sweep_ctrl_if.slave  bus
);
    localparam int IW = $clog2(I);
    localparam int TW = $clog2(TIMEOUT);
    localparam logic [TW-1:0]        TMO_LAST = TW'(TIMEOUT - 1);
    localparam logic [BIT_WIDTH-1:0] MAX_POS  = {1'b0, {(BIT_WIDTH-1){1'b1}}};

    typedef enum logic [2:0] {IDLE, LAUNCH, COLLECT, WRITE, FINISH} state_t;

    state_t               state;
    logic [IW-1:0]        last_i;
    logic [IW-1:0]        i_cnt;
    logic [IW-1:0]        j_exp;
    logic [BIT_WIDTH-1:0] best_val;
    logic [IW-1:0]        best_arg;
    logic [TW-1:0]        tmo;

    // Reduction including the incoming sample, so the final-j cycle writes the complete result.
    logic                 take;
    logic [BIT_WIDTH-1:0] nxt_val;
    logic [IW-1:0]        nxt_arg;

    always_comb begin
        take    = $signed(bus.emin_data_in) < $signed(best_val);
        nxt_val = take ? bus.emin_data_in : best_val;
        nxt_arg = take ? bus.emin_j_in    : best_arg;
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state              <= IDLE;
            last_i             <= '0;
            i_cnt              <= '0;
            j_exp              <= '0;
            best_val           <= '0;
            best_arg           <= '0;
            tmo                <= '0;
            bus.emin_i_out     <= '0;
            bus.emin_valid_out <= 1'b0;
            bus.res_we_out     <= 1'b0;
            bus.res_addr_out   <= '0;
            bus.res_val_out    <= '0;
            bus.res_arg_out    <= '0;
            bus.busy_out       <= 1'b0;
            bus.done_out       <= 1'b0;
            bus.error_out      <= 1'b0;
        end else begin
            bus.emin_valid_out <= 1'b0;
            bus.res_we_out     <= 1'b0;
            bus.done_out       <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start_in) begin
                        last_i             <= bus.last_i_in;
                        i_cnt              <= '0;
                        bus.error_out      <= 1'b0;
                        bus.busy_out       <= 1'b1;
                        bus.emin_i_out     <= '0;
                        bus.emin_valid_out <= 1'b1;
                        state              <= LAUNCH;
                    end
                end
                LAUNCH: begin
                    j_exp    <= '0;
                    best_val <= MAX_POS;
                    best_arg <= '0;
                    tmo      <= '0;
                    state    <= COLLECT;
                end
                COLLECT: begin
                    if (bus.emin_valid_in) begin
                        if (bus.emin_j_in != j_exp) begin
                            bus.error_out <= 1'b1;
                            bus.busy_out  <= 1'b0;
                            state         <= IDLE;
                        end else begin
                            best_val <= nxt_val;
                            best_arg <= nxt_arg;
                            j_exp    <= j_exp + 1'b1;
                            tmo      <= '0;
                            if (bus.emin_j_in == i_cnt) begin
                                bus.res_we_out   <= 1'b1;
                                bus.res_addr_out <= i_cnt;
                                bus.res_val_out  <= nxt_val;
                                bus.res_arg_out  <= nxt_arg;
                                state            <= WRITE;
                            end
                        end
                    end else if (tmo == TMO_LAST) begin
                        bus.error_out <= 1'b1;
                        bus.busy_out  <= 1'b0;
                        state         <= IDLE;
                    end else begin
                        tmo <= tmo + 1'b1;
                    end
                end
                WRITE: begin
                    if (i_cnt == last_i) begin
                        bus.done_out <= 1'b1;
                        state        <= FINISH;
                    end else begin
                        i_cnt              <= i_cnt + 1'b1;
                        bus.emin_i_out     <= i_cnt + 1'b1;
                        bus.emin_valid_out <= 1'b1;
                        state              <= LAUNCH;
                    end
                end
                FINISH: begin
                    bus.busy_out <= 1'b0;
                    state        <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
